// File: rtl/usb_rx_packet_ctrl.sv
// USB RX packet controller: PID check, 2-byte CRC holdback, payload
// forwarding to the RX FIFO and per-packet status with ready/ack.
module usb_rx_packet_ctrl #(
  parameter int MAX_BYTES = 64,
  parameter int CNT_W     = 7
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rcving,
  input  logic             w_enable,
  input  logic             r_error,
  input  logic [7:0]       rcv_data,
  input  logic             fifo_full,
  input  logic             pkt_ack,
  output logic [7:0]       payload_data,
  output logic             payload_we,
  output logic [3:0]       pid,
  output logic [CNT_W-1:0] byte_count,
  output logic             pkt_ready,
  output logic [2:0]       pkt_err
);

  typedef enum logic [2:0] {
    S_IDLE, S_PID, S_PAYLOAD, S_DONE, S_ERROR
  } state_t;

  localparam logic [2:0] E_NONE  = 3'd0;
  localparam logic [2:0] E_PID   = 3'd1;
  localparam logic [2:0] E_RX    = 3'd2;
  localparam logic [2:0] E_OVF   = 3'd3;
  localparam logic [2:0] E_SHORT = 3'd4;

  state_t     state;
  logic       rcving_d;
  logic [7:0] b0, b1;
  logic [1:0] fill;

  logic       start, stop, pid_ok;
  logic       fwd_due, ovf;
  logic [1:0] fill_nx;

  assign start   = rcving & ~rcving_d;
  assign stop    = ~rcving & rcving_d;
  assign pid_ok  = rcv_data[7:4] == ~rcv_data[3:0];
  assign fwd_due = w_enable && (fill == 2'd2);
  assign ovf     = fwd_due &&
                   (fifo_full || byte_count == CNT_W'(MAX_BYTES));
  assign fill_nx = (w_enable && fill != 2'd2) ? fill + 2'd1 : fill;

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= S_IDLE;
      rcving_d     <= 1'b0;
      b0           <= '0;
      b1           <= '0;
      fill         <= '0;
      payload_data <= '0;
      payload_we   <= 1'b0;
      pid          <= '0;
      byte_count   <= '0;
      pkt_ready    <= 1'b0;
      pkt_err      <= E_NONE;
    end else begin
      rcving_d   <= rcving;
      payload_we <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (start) begin
            byte_count <= '0;
            pid        <= '0;
            pkt_err    <= E_NONE;
            fill       <= '0;
            state      <= S_PID;
          end
        end
        S_PID: begin
          if (r_error) begin
            pkt_err   <= E_RX;
            pkt_ready <= 1'b1;
            state     <= S_ERROR;
          end else if (w_enable) begin
            if (!pid_ok) begin
              pkt_err   <= E_PID;
              pkt_ready <= 1'b1;
              state     <= S_ERROR;
            end else begin
              pid <= rcv_data[3:0];
              // PID byte and end together: handshake packet
              if (stop) begin
                pkt_ready <= 1'b1;
                state     <= S_DONE;
              end else begin
                state <= S_PAYLOAD;
              end
            end
          end else if (stop) begin
            pkt_err   <= E_SHORT;
            pkt_ready <= 1'b1;
            state     <= S_ERROR;
          end
        end
        S_PAYLOAD: begin
          if (r_error) begin
            pkt_err   <= E_RX;
            pkt_ready <= 1'b1;
            state     <= S_ERROR;
          end else if (ovf) begin
            pkt_err   <= E_OVF;
            pkt_ready <= 1'b1;
            state     <= S_ERROR;
          end else begin
            if (w_enable) begin
              b1   <= b0;
              b0   <= rcv_data;
              fill <= fill_nx;
              if (fwd_due) begin
                payload_data <= b1;
                payload_we   <= 1'b1;
                byte_count   <= byte_count + CNT_W'(1);
              end
            end
            // holdback content at end is the CRC
            if (stop) begin
              pkt_ready <= 1'b1;
              if (fill_nx == 2'd1) begin
                pkt_err <= E_SHORT;
                state   <= S_ERROR;
              end else begin
                state <= S_DONE;
              end
            end
          end
        end
        S_DONE, S_ERROR: begin
          if (pkt_ack) begin
            pkt_ready <= 1'b0;
            state     <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_usb_rx_packet_ctrl.sv
// Bench for usb_rx_packet_ctrl: packet-level reference model checked
// every cycle, directed packets with literal expectations, random packets.
module tb_usb_rx_packet_ctrl;

  localparam int MAXB = 4;
  localparam int CW   = 7;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          rcving = 1'b0;
  logic          w_enable = 1'b0;
  logic          r_error = 1'b0;
  logic [7:0]    rcv_data = '0;
  logic          fifo_full = 1'b0;
  logic          pkt_ack = 1'b0;
  logic [7:0]    payload_data;
  logic          payload_we;
  logic [3:0]    pid;
  logic [CW-1:0] byte_count;
  logic          pkt_ready;
  logic [2:0]    pkt_err;

  usb_rx_packet_ctrl #(.MAX_BYTES(MAXB), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .rcving(rcving), .w_enable(w_enable),
    .r_error(r_error), .rcv_data(rcv_data), .fifo_full(fifo_full),
    .pkt_ack(pkt_ack), .payload_data(payload_data),
    .payload_we(payload_we), .pid(pid), .byte_count(byte_count),
    .pkt_ready(pkt_ready), .pkt_err(pkt_err)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s t=%0t got=%0h want=%0h", nm, $time, act, exp);
    end
  endtask

  // Reference model: a packet is a PID byte followed by data whose last
  // two bytes are CRC; a byte leaves the holdback queue once two newer
  // bytes are behind it.
  bit         m_rd, m_busy, m_have, m_ready, m_on;
  logic [7:0] hb[$];
  logic [7:0] wr_q[$];
  logic       e_we;
  logic [7:0] e_data;
  logic [3:0] e_pid;
  int         e_cnt;
  logic [2:0] e_err;
  bit         m_st, m_en, m_fin;
  int         m_e;

  task automatic model_step();
    e_we = 1'b0;
    m_st = rcving && !m_rd;
    m_en = !rcving && m_rd;
    m_rd = rcving;
    if (rst) begin
      m_on = 1; m_rd = 0; m_busy = 0; m_have = 0; m_ready = 0;
      hb.delete();
      e_data = 0; e_pid = 0; e_cnt = 0; e_err = 0;
    end else if (m_ready) begin
      if (pkt_ack) m_ready = 0;
    end else if (!m_busy) begin
      if (m_st) begin
        m_busy = 1; m_have = 0; hb.delete();
        e_pid = 0; e_cnt = 0; e_err = 0;
      end
    end else if (r_error) begin
      m_busy = 0; m_ready = 1; e_err = 3'd2;
    end else begin
      m_fin = 0; m_e = 0;
      if (w_enable) begin
        if (!m_have) begin
          if (rcv_data[7:4] == ~rcv_data[3:0]) begin
            m_have = 1; e_pid = rcv_data[3:0];
          end else begin
            m_fin = 1; m_e = 1;
          end
        end else begin
          hb.push_back(rcv_data);
          if (hb.size() > 2) begin
            if (fifo_full || e_cnt == MAXB) begin
              m_fin = 1; m_e = 3;
            end else begin
              e_data = hb.pop_front();
              e_we = 1'b1;
              e_cnt++;
            end
          end
        end
      end
      if (!m_fin && m_en) begin
        m_fin = 1;
        m_e = (!m_have || hb.size() == 1) ? 4 : 0;
      end
      if (m_fin) begin
        m_busy = 0; m_ready = 1; e_err = 3'(m_e);
      end
    end
  endtask

  always @(posedge clk) begin
    model_step();
    #1;
    if (m_on) begin
      chk("we", payload_we, e_we);
      chk("data", payload_data, e_data);
      chk("pid", pid, e_pid);
      chk("count", byte_count, e_cnt);
      chk("ready", pkt_ready, m_ready);
      chk("err", pkt_err, e_err);
    end
    if (payload_we === 1'b1) wr_q.push_back(payload_data);
  end

  task automatic tick(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  task automatic byte_in(input logic [7:0] b, input bit end_now = 1'b0);
    rcv_data = b;
    w_enable = 1'b1;
    if (end_now) rcving = 1'b0;
    tick(1);
    w_enable = 1'b0;
    tick(1);
  endtask

  task automatic pkt_begin();
    wr_q.delete();
    rcving = 1'b1;
    tick(2);
  endtask

  task automatic pkt_end();
    rcving = 1'b0;
    tick(2);
  endtask

  task automatic expect_pkt(input string nm, input logic [3:0] p,
                            input int c, input int e, input int nw,
                            input logic [31:0] wv);
    int k = 0;
    while (pkt_ready !== 1'b1 && k < 40) begin
      tick(1);
      k++;
    end
    chk({nm, "_rdy"}, pkt_ready, 1);
    chk({nm, "_pid"}, pid, p);
    chk({nm, "_cnt"}, byte_count, c);
    chk({nm, "_err"}, pkt_err, e);
    chk({nm, "_nwr"}, wr_q.size(), nw);
    for (int i = 0; i < nw; i++)
      if (wr_q.size() > i) chk({nm, "_wr"}, wr_q[i], wv[8*i +: 8]);
    pkt_ack = 1'b1;
    tick(1);
    pkt_ack = 1'b0;
    chk({nm, "_ackrdy"}, pkt_ready, 0);
    tick(2);
  endtask

  task automatic check_zero(input string nm);
    chk({nm, "_we"}, payload_we, 0);
    chk({nm, "_data"}, payload_data, 0);
    chk({nm, "_pid"}, pid, 0);
    chk({nm, "_cnt"}, byte_count, 0);
    chk({nm, "_rdy"}, pkt_ready, 0);
    chk({nm, "_err"}, pkt_err, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog t=%0t", $time);
    $fatal(1, "timeout");
  end

  int         nb;
  logic [7:0] b;
  logic [3:0] nib;

  initial begin
    rst = 1'b1;
    tick(2);
    check_zero("reset");
    rst = 1'b0;
    tick(2);

    pkt_begin();
    byte_in(8'hC3); byte_in(8'h11); byte_in(8'h22);
    byte_in(8'h33); byte_in(8'hAA); byte_in(8'hBB);
    pkt_end();
    expect_pkt("data0", 4'h3, 3, 0, 3, 32'h0033_2211);

    pkt_begin();
    byte_in(8'hD2);
    pkt_end();
    expect_pkt("ack", 4'h2, 0, 0, 0, 32'h0);

    pkt_begin();
    byte_in(8'hC4); byte_in(8'h11);
    pkt_end();
    expect_pkt("badpid", 4'h0, 0, 1, 0, 32'h0);

    pkt_begin();
    byte_in(8'hC3); byte_in(8'h55);
    pkt_end();
    expect_pkt("short", 4'h3, 0, 4, 0, 32'h0);

    pkt_begin();
    byte_in(8'hC3); byte_in(8'h11); byte_in(8'h22); byte_in(8'h33);
    r_error = 1'b1;
    tick(1);
    r_error = 1'b0;
    tick(1);
    byte_in(8'h44);
    pkt_end();
    expect_pkt("rxerr", 4'h3, 1, 2, 1, 32'h11);

    pkt_begin();
    byte_in(8'hC3); byte_in(8'h11); byte_in(8'h22); byte_in(8'h33);
    fifo_full = 1'b1;
    byte_in(8'h44);
    fifo_full = 1'b0;
    pkt_end();
    expect_pkt("full", 4'h3, 1, 3, 1, 32'h11);

    pkt_begin();
    byte_in(8'hC3);
    for (int i = 1; i <= 7; i++) byte_in(8'(i));
    pkt_end();
    expect_pkt("max", 4'h3, 4, 3, 4, 32'h0403_0201);

    pkt_begin();
    byte_in(8'hC3); byte_in(8'h01); byte_in(8'hAA);
    byte_in(8'hBB, 1'b1);
    tick(1);
    expect_pkt("endsame", 4'h3, 1, 0, 1, 32'h01);

    pkt_begin();
    byte_in(8'hC3); byte_in(8'h01); byte_in(8'h02);
    byte_in(8'h03); byte_in(8'h04);
    chk("midrst_nwr", wr_q.size(), 2);
    rst = 1'b1;
    rcving = 1'b0;
    tick(1);
    check_zero("midrst");
    rst = 1'b0;
    tick(3);
    chk("midrst_idle", pkt_ready, 0);

    pkt_begin();
    byte_in(8'hD2);
    pkt_end();
    chk("held_rdy", pkt_ready, 1);
    wr_q.delete();
    rcving = 1'b1;
    tick(2);
    byte_in(8'hC3); byte_in(8'h11); byte_in(8'h22);
    pkt_ack = 1'b1;
    tick(1);
    pkt_ack = 1'b0;
    byte_in(8'h33); byte_in(8'hAA); byte_in(8'hBB);
    pkt_end();
    tick(2);
    chk("skip_nwr", wr_q.size(), 0);
    chk("skip_rdy", pkt_ready, 0);
    chk("skip_pid", pid, 2);

    for (int p = 0; p < 300; p++) begin
      rcving = 1'b1;
      tick(1 + int'($urandom_range(0, 1)));
      nb = int'($urandom_range(0, 9));
      for (int i = 0; i < nb; i++) begin
        nib = 4'($urandom);
        b = 8'($urandom);
        if (i == 0 && $urandom_range(0, 5) != 0) b = {~nib, nib};
        rcv_data  = b;
        w_enable  = 1'b1;
        fifo_full = ($urandom_range(0, 9) == 0);
        r_error   = ($urandom_range(0, 49) == 0);
        pkt_ack   = ($urandom_range(0, 15) == 0);
        if (i == nb - 1 && $urandom_range(0, 3) == 0) rcving = 1'b0;
        tick(1);
        w_enable = 1'b0;
        r_error  = 1'b0;
        pkt_ack  = 1'b0;
        if ($urandom_range(0, 59) == 0) begin
          rst = 1'b1;
          tick(1);
          rst = 1'b0;
        end
        tick(int'($urandom_range(0, 2)));
      end
      fifo_full = 1'b0;
      rcving = 1'b0;
      tick(1 + int'($urandom_range(0, 1)));
      if (m_ready && $urandom_range(0, 7) != 0) begin
        tick(int'($urandom_range(0, 2)));
        pkt_ack = 1'b1;
        tick(1);
        pkt_ack = 1'b0;
      end
      tick(1);
    end

    tick(3);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
